rx_control: RTL and testbench
=============================

// Module: rx_control
// PURPOSE
//  Receive-side word assembler for the UART link. Takes the byte stream from
//  the UART receiver, packs two consecutive bytes (low byte first, then high
//  byte) into one 16-bit word and presents it with a 1-cycle valid strobe.
//  Guards against lost bytes with an inter-byte timeout and discards partial
//  words on receiver errors. Sits between uart_rx and the consuming datapath.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max clk cycles between low and high byte (10 ms @ 100 MHz); >=2
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  reset        in   1   synchronous, active-high
//  rx_ready     in   1   1-cycle pulse from uart_rx: rx_data holds a new byte
//  rx_data      in   8   received byte, valid only when rx_ready=1
//  rx_error     in   1   1-cycle pulse from uart_rx: framing/stop-bit error
//  word_data    out  16  last assembled word {high,low}; held until next word
//  word_valid   out  1   1-cycle pulse: word_data updated this cycle
//  err          out  1   1-cycle pulse: partial word discarded (timeout or rx_error)
//  id           out  2   current state encoding (debug)
// BEHAVIOUR
//  Reset: state=IDLE, word_data=0, word_valid=0, err=0, low byte reg=0, timer=0.
//  All outputs registered. States: IDLE(0), WAIT_HI(1), DONE(2).
//  IDLE: rx_ready -> latch rx_data as low byte, clear timer, -> WAIT_HI.
//        rx_error in IDLE -> ignored (no err pulse).
//  WAIT_HI: timer increments each cycle without rx_ready.
//   - rx_ready -> word_data<={rx_data,low}, -> DONE; word_valid=1 on the cycle
//     after the high-byte rx_ready (latency 1 cycle), same edge as word_data.
//   - rx_error (with or without rx_ready) -> discard low byte, err=1 next cycle, -> IDLE.
//   - timer==TIMEOUT_CYCLES-1 and no rx_ready -> err=1 next cycle, -> IDLE.
//   - rx_ready on the expiry cycle: byte wins, word completes, no err.
//  DONE: word_valid high this cycle only. rx_ready here is a new low byte:
//        latch it, clear timer, -> WAIT_HI (no byte dropped). Else -> IDLE.
//  rx_ready and rx_error both high in IDLE/DONE: error wins, byte dropped, -> IDLE.
//  word_valid and err never high in the same cycle.
//  Timer width $clog2(TIMEOUT_CYCLES); saturates, never wraps.
//  Reset mid-word: partial low byte lost, no err pulse, word_data cleared to 0.
//  Back-to-back bytes on consecutive cycles supported at full rate.
// STRUCTURE
//  uart_pkg: rx_state_t enum {IDLE,WAIT_HI,DONE} (logic [1:0]), WORD_W=16,
//   BYTE_W=8; shared with tx_control.
//  Sub-module: timeout_timer (clear, enable, expired; parameter TIMEOUT_CYCLES).
//  Top: one always_comb next-state/next-data block, one always_ff register block.
// TESTING
//  1 rx_ready 0x34 then 0x12 five cycles later -> word_data=16'h1234, word_valid 1 cycle, 1 cycle after 2nd byte.
//  2 bytes 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles -> words 16'hBBAA then 16'hDDCC, no err.
//  3 TIMEOUT_CYCLES=100: byte 0x55, silence -> err pulse after 100 cycles, IDLE; next 0x01,0x02 -> 16'h0201.
//  4 byte 0x11, then rx_error -> err pulse, no word_valid; word_data keeps previous value.
//  5 TIMEOUT_CYCLES=100: high byte 0x77 on exact expiry cycle -> word_valid, no err.
//  6 reset asserted in WAIT_HI -> id=0, word_data=0, no err; next two bytes assemble normally.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART link control blocks (rx_control and
//   tx_control): data widths and the receive-side state encoding.
//
//   Contents
//     BYTE_W      width of one UART character
//     WORD_W      width of one assembled datapath word (two characters)
//     rx_state_t  receive word-assembler state
//     pack_word   helper that forms {high, low} from two bytes
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // The encoding is visible on the rx_control debug port (id).
    // Software tools decode it, so these values must not be renumbered.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        DONE    = 2'd2
    } rx_state_t;

    // Words are sent low byte first.
    // The first byte received is therefore the low half of the word.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [BYTE_W-1:0] hi,
        input logic [BYTE_W-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage : uart_pkg

// File: rtl/timeout_timer.sv
// -----------------------------------------------------------------------------
// timeout_timer
//   Counts clk cycles while enabled and flags when TIMEOUT_CYCLES-1 has been
//   reached. The counter saturates at that value and never wraps, so a stuck
//   enable cannot produce a second, spurious expiry.
//
//   Parameters
//     TIMEOUT_CYCLES  number of counted cycles that make up one timeout (>= 2)
//
//   Ports
//     clk      in   1  system clock
//     reset    in   1  synchronous, active-high; count returns to 0
//     clear    in   1  restart counting from 0 (has priority over enable)
//     enable   in   1  advance the count by one this cycle
//     expired  out  1  count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Derived from a register.
    // The owner samples it in the same cycle that it holds.
    assign expired = (count_q == LAST);

endmodule : timeout_timer

// File: rtl/rx_control.sv
// -----------------------------------------------------------------------------
// rx_control
//   Receive-side word assembler. Two consecutive bytes from uart_rx (low byte
//   first) are packed into one 16-bit word and announced with a one-cycle
//   strobe. If the high byte does not arrive within TIMEOUT_CYCLES, the partial
//   word is dropped and err pulses. A receiver error also drops the partial
//   word and pulses err.
//
//   Parameters
//     TIMEOUT_CYCLES  max cycles allowed between low and high byte (>= 2)
//
//   Ports
//     clk         in   1   system clock
//     reset       in   1   synchronous, active-high
//     rx_ready    in   1   pulse: rx_data carries a new byte
//     rx_data     in   8   received byte
//     rx_error    in   1   pulse: framing / stop-bit error in uart_rx
//     word_data   out  16  last assembled word {high,low}, held between words
//     word_valid  out  1   pulse: word_data was updated this cycle
//     err         out  1   pulse: partial word discarded
//     id          out  2   current state encoding (debug)
// -----------------------------------------------------------------------------
module rx_control
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_error,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              err,
    output logic [1:0]        id
);

    rx_state_t         state_q, state_d;
    logic [BYTE_W-1:0] low_q, low_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    // The timer only runs in WAIT_HI.
    // It is held at zero in every other state. As a result, WAIT_HI is always
    // entered with a fresh count, whether it is entered from IDLE or from DONE.
    assign timer_clear  = (state_q != WAIT_HI);
    assign timer_enable = (state_q == WAIT_HI) && !rx_ready;

    timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        word_d  = word_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // No partial word is held here.
                // A receiver error is therefore silently ignored.
                if (rx_error) begin
                    state_d = IDLE;
                end else if (rx_ready) begin
                    low_d   = rx_data;
                    state_d = WAIT_HI;
                end
            end

            WAIT_HI: begin
                if (rx_error) begin
                    // An error with a simultaneous byte still aborts.
                    // The low byte cannot be trusted to pair with it.
                    low_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (rx_ready) begin
                    // A byte on the expiry cycle still completes the word.
                    word_d  = pack_word(rx_data, low_q);
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (timer_expired) begin
                    low_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            DONE: begin
                // A byte here is the low half of the next word.
                // It is taken straight away, so full-rate streams lose nothing.
                if (rx_error) begin
                    state_d = IDLE;
                end else if (rx_ready) begin
                    low_d   = rx_data;
                    state_d = WAIT_HI;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                low_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            low_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign word_data  = word_q;
    assign word_valid = valid_q;
    assign err        = err_q;
    assign id         = state_q;

endmodule : rx_control

// File: tb/tb_rx_control.sv
module tb_rx_control;

    localparam int T = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_error;
    logic [15:0] word_data;
    logic        word_valid;
    logic        err;
    logic [1:0]  id;

    int total = 0;
    int bad   = 0;
    int seen_err;
    int seen_valid;

    rx_control #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_error  (rx_error),
        .word_data (word_data),
        .word_valid(word_valid),
        .err       (err),
        .id        (id)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge.
    // Outputs are therefore checked away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_error = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_id", 32'(id), 32'h0);
        chk("rst_word", 32'(word_data), 32'h0);
        chk("rst_valid", 32'(word_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // 1: 0x34, gap, 0x12 -> 0x1234 one cycle after the high byte
        send(8'h34);
        chk("t1_id_wait", 32'(id), 32'h1);
        chk("t1_no_valid", 32'(word_valid), 32'h0);
        repeat (4) tick();
        send(8'h12);
        chk("t1_valid", 32'(word_valid), 32'h1);
        chk("t1_word", 32'(word_data), 32'h1234);
        chk("t1_id_done", 32'(id), 32'h2);
        tick();
        chk("t1_valid_drop", 32'(word_valid), 32'h0);
        chk("t1_id_idle", 32'(id), 32'h0);
        chk("t1_word_hold", 32'(word_data), 32'h1234);

        // 2: back-to-back bytes at full rate
        send(8'hAA);
        chk("t2_valid0", 32'(word_valid), 32'h0);
        send(8'hBB);
        chk("t2_valid1", 32'(word_valid), 32'h1);
        chk("t2_word1", 32'(word_data), 32'hBBAA);
        send(8'hCC);
        chk("t2_valid2", 32'(word_valid), 32'h0);
        chk("t2_id_wait", 32'(id), 32'h1);
        send(8'hDD);
        chk("t2_valid3", 32'(word_valid), 32'h1);
        chk("t2_word2", 32'(word_data), 32'hDDCC);
        chk("t2_err", 32'(err), 32'h0);
        tick();

        // 3: timeout -> err exactly T cycles after the low byte, then recovery
        send(8'h55);
        seen_err = 0;
        for (int i = 0; i < T - 1; i++) begin
            tick();
            if (err) seen_err++;
        end
        chk("t3_no_early_err", 32'(seen_err), 32'h0);
        chk("t3_still_wait", 32'(id), 32'h1);
        tick();
        chk("t3_err", 32'(err), 32'h1);
        chk("t3_id_idle", 32'(id), 32'h0);
        chk("t3_no_valid", 32'(word_valid), 32'h0);
        tick();
        chk("t3_err_drop", 32'(err), 32'h0);
        send(8'h01);
        send(8'h02);
        chk("t3_valid", 32'(word_valid), 32'h1);
        chk("t3_word", 32'(word_data), 32'h0201);
        tick();

        // 5: high byte on the exact expiry cycle completes the word
        send(8'h66);
        repeat (T - 1) tick();
        send(8'h77);
        chk("t5_valid", 32'(word_valid), 32'h1);
        chk("t5_err", 32'(err), 32'h0);
        chk("t5_word", 32'(word_data), 32'h7766);
        tick();
        chk("t5_err_after", 32'(err), 32'h0);

        // 4: rx_error mid-word -> err, word_data keeps the previous word
        send(8'h11);
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
        chk("t4_err", 32'(err), 32'h1);
        chk("t4_no_valid", 32'(word_valid), 32'h0);
        chk("t4_id_idle", 32'(id), 32'h0);
        chk("t4_word_hold", 32'(word_data), 32'h7766);
        tick();
        chk("t4_err_drop", 32'(err), 32'h0);

        // rx_error while IDLE is ignored
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
        chk("idle_err_ignored", 32'(err), 32'h0);
        chk("idle_err_id", 32'(id), 32'h0);

        // rx_error and rx_ready together in WAIT_HI: error wins
        send(8'h21);
        rx_error = 1'b1;
        send(8'h43);
        rx_error = 1'b0;
        chk("both_wait_err", 32'(err), 32'h1);
        chk("both_wait_valid", 32'(word_valid), 32'h0);
        chk("both_wait_word", 32'(word_data), 32'h7766);

        // 6: reset in WAIT_HI drops the partial word and clears word_data
        tick();
        send(8'h5A);
        chk("t6_id_wait", 32'(id), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_id", 32'(id), 32'h0);
        chk("t6_word", 32'(word_data), 32'h0);
        chk("t6_err", 32'(err), 32'h0);
        seen_err = 0;
        seen_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (err) seen_err++;
            if (word_valid) seen_valid++;
        end
        chk("t6_quiet_err", 32'(seen_err), 32'h0);
        chk("t6_quiet_valid", 32'(seen_valid), 32'h0);
        send(8'hC3);
        send(8'h3C);
        chk("t6_valid", 32'(word_valid), 32'h1);
        chk("t6_word2", 32'(word_data), 32'h3CC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rx_control
